// File: rtl/ram_loader_pkg.sv
// Shared sizing and FSM encoding for the byte-stream RAM loader.
package ram_loader_pkg;
  localparam int DEF_ADDR_W     = 10;
  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_DATA_W     = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_VERIFY  = 3'd3,
    S_DONE    = 3'd4
  } state_t;
endpackage

// File: rtl/ram_loader_if.sv
// Byte-stream input plus data-RAM port; the loader sits on the master side.
interface ram_loader_if
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_str;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  in_byte, in_valid, mem_rdata,
    output in_ready, mem_addr, mem_data, mem_str
  );

  modport slave (
    output in_byte, in_valid, mem_rdata,
    input  in_ready, mem_addr, mem_data, mem_str
  );
endinterface

// File: rtl/ram_loader_word_assembler.sv
// Packs accepted bytes little-endian into words; word_last flags the accept that completes
// a word (same cycle), word_vld pulses the cycle after while word_dat holds the packed word.
module word_assembler
  import ram_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              accept,
  input  logic [7:0]        in_byte,
  output logic [DATA_W-1:0] word_dat,
  output logic              word_vld,
  output logic              word_last
);
  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0] byte_cnt;

  assign word_last = accept && (byte_cnt == LAST_BYTE);

  // Shifting right lands the first byte in [7:0] once the word is complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      word_dat <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= word_last;
      if (clr) begin
        byte_cnt <= '0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
        word_dat <= {in_byte, word_dat[DATA_W-1:8]};
      end
    end
  end
endmodule

// File: rtl/ram_loader.sv
// Loads word_count words from a byte stream into RAM at base_addr, then reads them back to
// verify the running checksum; one WRITE cycle per word, in_ready only while collecting.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  ram_loader_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q, index, index_inc;
  logic [DATA_W-1:0] verify_sum, vsum_nxt, word_dat;
  logic              word_vld, word_last, start_ok, accept;

  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  assign accept    = bus.in_valid && bus.in_ready;
  assign index_inc = index + {{ADDR_W{1'b0}}, 1'b1};
  assign vsum_nxt  = verify_sum + bus.mem_rdata;
  assign bus.mem_addr = base_q + index[ADDR_W-1:0];

  word_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_ok),
    .accept    (accept),
    .in_byte   (bus.in_byte),
    .word_dat  (word_dat),
    .word_vld  (word_vld),
    .word_last (word_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (word_count == '0) ? S_DONE : S_COLLECT;
      S_COLLECT:      if (word_last) state_nxt = S_WRITE;
      S_WRITE:        state_nxt = (index_inc < count_q) ? S_COLLECT : S_VERIFY;
      S_VERIFY:       if (index_inc == count_q) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.mem_str  = 1'b0;
    bus.mem_data = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_COLLECT: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
      end
      S_WRITE: begin
        bus.mem_str  = 1'b1;
        bus.mem_data = word_dat;
        busy         = 1'b1;
      end
      S_VERIFY: busy = 1'b1;
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  // index walks the write addresses, then restarts from 0 for the read-back pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      count_q    <= '0;
      index      <= '0;
      checksum   <= '0;
      verify_sum <= '0;
      error      <= 1'b0;
    end else if (start_ok) begin
      base_q     <= base_addr;
      count_q    <= word_count;
      index      <= '0;
      checksum   <= '0;
      verify_sum <= '0;
      error      <= 1'b0;
    end else begin
      case (state)
        S_WRITE: begin
          if (word_vld) checksum <= checksum + word_dat;
          index <= (index_inc < count_q) ? index_inc : '0;
        end
        S_VERIFY: begin
          verify_sum <= vsum_nxt;
          if (index_inc == count_q) begin
            index <= '0;
            error <= (vsum_nxt != checksum);
          end else begin
            index <= index_inc;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
